// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall sequencing, dmem-busy freeze and
// branch flush for the 5-stage core, with saturating stall/flush counters.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_memread_i,
    input  logic              br_taken_i,
    input  logic              dmem_busy_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              id_ex_write_o,
    output logic              id_ex_bubble_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
    output logic              state_dbg_o,
    output logic [2:0]        wait_dbg_o
);

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              stall_inc, flush_inc;
    logic              rs1_hit, rs2_hit, hazard;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign hazard  = ex_memread_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        state_d        = state_q;
        wait_d         = wait_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        // While reset is asserted the outputs stay at their defaults whatever the inputs.
        if (!rst_n_i) begin
            state_d = RUN;
            wait_d  = '0;
        end else if (dmem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_write_o = 1'b0;
        end else if (br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            flush_inc     = 1'b1;
            state_d       = RUN;
            wait_d        = '0;
        end else if (state_q == LOAD_WAIT) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_inc      = 1'b1;
            wait_d         = wait_q - 3'd1;
            if (wait_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (hazard) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_inc      = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LOAD_WAIT;
                wait_d  = 3'(LOAD_LAT - 1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign state_dbg_o = state_q;
    assign wait_dbg_o  = wait_q;

endmodule
